mem_arbiter: RTL and testbench

//   Shares one unified 128-bit-line main memory between the instruction-cache and data-cache miss ports.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the unified memory arbiter.
// The arbiter uses slave; caches and the memory model use master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [LINE_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;

  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [LINE_W-1:0] D_WRITEDATA;
  logic [LINE_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;

  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [LINE_W-1:0] MEM_WRITEDATA;
  logic [LINE_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  logic              ARB_ERR;

  modport slave (
    input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, ARB_ERR
  );

  modport master (
    output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, ARB_ERR
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one line-wide main memory between icache and dcache miss ports, one transaction at a time.
// States: S_IDLE arbitrate+latch | S_ISSUE first strobe cycle | S_WAIT memory or watchdog | S_DONE release owner
module mem_arbiter #(
  parameter int ADDR_W   = 28,
  parameter int LINE_W   = 128,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic         CLK,
  input  logic         RESET,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  localparam logic       FIXED_D   = (ARB_MODE == 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  owner_t            r_owner;
  logic              r_last_d;
  logic [7:0]        r_wait_cnt;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              r_err;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;

  assign w_i_req = bus.I_READ;
  assign w_d_req = bus.D_READ | bus.D_WRITE;
  // With both ports requesting, round-robin hands the grant to whoever did not win last time
  assign w_grant_d = w_d_req & (~w_i_req | FIXED_D | ~r_last_d);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_last_d    <= 1'b0;
      r_wait_cnt  <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (bus.D_READ && bus.D_WRITE) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_i_req || w_d_req) begin
            r_state    <= S_ISSUE;
            r_wait_cnt <= '0;
            if (w_grant_d) begin
              r_owner     <= OWN_D;
              r_mem_addr  <= bus.D_ADDRESS;
              r_mem_read  <= ~bus.D_WRITE;
              r_mem_write <= bus.D_WRITE;
              if (bus.D_WRITE) r_mem_wdata <= bus.D_WRITEDATA;
            end else begin
              r_owner     <= OWN_I;
              r_mem_addr  <= bus.I_ADDRESS;
              r_mem_read  <= 1'b1;
              r_mem_write <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          if (!bus.MEM_BUSYWAIT) begin
            if (!r_mem_write) begin
              if (r_owner == OWN_D) r_d_rdata <= bus.MEM_READDATA;
              else                  r_i_rdata <= bus.MEM_READDATA;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= S_DONE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_err       <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_last_d <= (r_owner == OWN_D);
          r_owner  <= OWN_NONE;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.I_BUSYWAIT    = bus.I_READ & ~((r_state == S_DONE) && (r_owner == OWN_I));
  assign bus.D_BUSYWAIT    = w_d_req & ~((r_state == S_DONE) && (r_owner == OWN_D));
  assign bus.I_READDATA    = r_i_rdata;
  assign bus.D_READDATA    = r_d_rdata;
  assign bus.MEM_READ      = r_mem_read;
  assign bus.MEM_WRITE     = r_mem_write;
  assign bus.MEM_ADDRESS   = r_mem_addr;
  assign bus.MEM_WRITEDATA = r_mem_wdata;
  assign bus.ARB_ERR       = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance b0 and fixed-priority instance b1.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int LW = 128;
  localparam int TO = 255;
  localparam logic [LW-1:0] A5 = {16{8'hA5}};
  localparam logic [LW-1:0] X5A = {16{8'h5A}};

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) b0 ();
  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) b1 ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .ARB_MODE(0), .TIMEOUT(TO)) u_rr (
    .CLK(CLK), .RESET(RESET), .bus(b0));
  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .ARB_MODE(1), .TIMEOUT(TO)) u_fp (
    .CLK(CLK), .RESET(RESET), .bus(b1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // memory models: ready once the strobe has been seen for more than lat edges
  int lat0 = 0, lat1 = 0, mcnt0 = 0, mcnt1 = 0;
  logic stuck0 = 1'b0, stuck1 = 1'b0;
  logic [LW-1:0] rdata0 = '0, rdata1 = '0;
  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    mcnt0 <= (b0.MEM_READ | b0.MEM_WRITE) ? mcnt0 + 1 : 0;
    mcnt1 <= (b1.MEM_READ | b1.MEM_WRITE) ? mcnt1 + 1 : 0;
  end
  assign b0.MEM_BUSYWAIT = stuck0 | !(mcnt0 > lat0);
  assign b1.MEM_BUSYWAIT = stuck1 | !(mcnt1 > lat1);
  assign b0.MEM_READDATA = rdata0;
  assign b1.MEM_READDATA = rdata1;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } ent_t;
  ent_t log0[$], log1[$];
  int   logc0[$];
  logic prev0 = 1'b0, prev1 = 1'b0;
  always @(negedge CLK) begin
    if ((b0.MEM_READ | b0.MEM_WRITE) && !prev0) begin
      log0.push_back({b0.MEM_WRITE, b0.MEM_ADDRESS, b0.MEM_WRITEDATA});
      logc0.push_back(cyc);
    end
    if ((b1.MEM_READ | b1.MEM_WRITE) && !prev1)
      log1.push_back({b1.MEM_WRITE, b1.MEM_ADDRESS, b1.MEM_WRITEDATA});
    prev0 <= b0.MEM_READ | b0.MEM_WRITE;
    prev1 <= b1.MEM_READ | b1.MEM_WRITE;
  end

  typedef struct {
    logic          i_rd, d_rd, d_wr, own_d;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] wdata, rdata;
    int            lat;
    logic          exp_rd, exp_wr;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wdata, exp_i, exp_d;
    logic          exp_err;
    int            exp_cyc;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int   base0, base1, cyc_n, scnt, lows, first_low, d_done, d_hi;
    logic got, fin, dropped, err_last, s_rd, s_wr;
    logic [AW-1:0] s_addr;
    logic [LW-1:0] s_wdata;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 28'h10, 28'h0, '0, A5, 5,
                1'b1, 1'b0, 28'h10, '0, A5, '0, 1'b0, 9};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 28'h0, 28'h22, '0, 128'hC3, 0,
                1'b1, 1'b0, 28'h22, '0, A5, 128'hC3, 1'b0, 4};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 28'h0, 28'h3, 128'h1234, '0, 2,
                1'b0, 1'b1, 28'h3, 128'h1234, A5, 128'hC3, 1'b0, 6};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 28'hFFFFFFF, 28'h0, '0, X5A, 1,
                1'b1, 1'b0, 28'hFFFFFFF, 128'h1234, X5A, 128'hC3, 1'b0, 5};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 28'h0, 28'h44, 128'hBEEF, 128'h77, 0,
                1'b0, 1'b1, 28'h44, 128'hBEEF, X5A, 128'hC3, 1'b1, 4};

    b0.I_READ = 1'b0; b0.I_ADDRESS = '0; b0.D_READ = 1'b0; b0.D_WRITE = 1'b0;
    b0.D_ADDRESS = '0; b0.D_WRITEDATA = '0;
    b1.I_READ = 1'b0; b1.I_ADDRESS = '0; b1.D_READ = 1'b0; b1.D_WRITE = 1'b0;
    b1.D_ADDRESS = '0; b1.D_WRITEDATA = '0;

    // reset with requests pending, then first grant with both requesting
    #1 RESET = 1'b0;
    b0.I_READ = 1'b1; b0.I_ADDRESS = 28'h77; b0.D_READ = 1'b1; b0.D_ADDRESS = 28'h55;
    repeat (3) @(negedge CLK);
    chk("rst_mem_read", LW'(b0.MEM_READ), '0);
    chk("rst_i_rdata", b0.I_READDATA, '0);
    chk("rst_err", LW'(b0.ARB_ERR), '0);
    chk("rst_mem_addr", LW'(b0.MEM_ADDRESS), '0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("first_grant_addr", LW'(b0.MEM_ADDRESS), LW'(28'h55));
    chk("first_grant_rd", LW'(b0.MEM_READ), LW'(1'b1));
    b0.I_READ = 1'b0; b0.D_READ = 1'b0;
    do_reset();

    for (int v = 0; v < 5; v++) begin
      lat0 = vecs[v].lat; rdata0 = vecs[v].rdata;
      b0.I_READ = vecs[v].i_rd; b0.I_ADDRESS = vecs[v].i_addr;
      b0.D_READ = vecs[v].d_rd; b0.D_WRITE = vecs[v].d_wr;
      b0.D_ADDRESS = vecs[v].d_addr; b0.D_WRITEDATA = vecs[v].wdata;
      cyc_n = 1; got = 1'b0; s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge CLK);
        cyc_n++;
        if (b0.MEM_READ | b0.MEM_WRITE) begin
          s_rd = b0.MEM_READ; s_wr = b0.MEM_WRITE;
          s_addr = b0.MEM_ADDRESS; s_wdata = b0.MEM_WRITEDATA;
        end
        if (!(vecs[v].own_d ? b0.D_BUSYWAIT : b0.I_BUSYWAIT)) got = 1'b1;
      end
      chk($sformatf("v%0d_done", v), LW'(got), LW'(1'b1));
      chk($sformatf("v%0d_cycles", v), LW'(cyc_n), LW'(vecs[v].exp_cyc));
      chk($sformatf("v%0d_mem_read", v), LW'(s_rd), LW'(vecs[v].exp_rd));
      chk($sformatf("v%0d_mem_write", v), LW'(s_wr), LW'(vecs[v].exp_wr));
      chk($sformatf("v%0d_mem_addr", v), LW'(s_addr), LW'(vecs[v].exp_addr));
      chk($sformatf("v%0d_mem_wdata", v), s_wdata, vecs[v].exp_wdata);
      chk($sformatf("v%0d_i_rdata", v), b0.I_READDATA, vecs[v].exp_i);
      chk($sformatf("v%0d_d_rdata", v), b0.D_READDATA, vecs[v].exp_d);
      chk($sformatf("v%0d_err", v), LW'(b0.ARB_ERR), LW'(vecs[v].exp_err));
      b0.I_READ = 1'b0; b0.D_READ = 1'b0; b0.D_WRITE = 1'b0;
      @(negedge CLK);
    end
    do_reset();

    // requester drops mid-transaction, address change after grant ignored
    lat0 = 3; rdata0 = 128'h99;
    b0.I_READ = 1'b1; b0.I_ADDRESS = 28'h30;
    repeat (2) @(negedge CLK);
    b0.I_READ = 1'b0; b0.I_ADDRESS = 28'h31;
    @(negedge CLK);
    chk("drop_addr_held", LW'(b0.MEM_ADDRESS), LW'(28'h30));
    chk("drop_strobe_held", LW'(b0.MEM_READ), LW'(1'b1));
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      if (!b0.MEM_READ) got = 1'b1;
    end
    chk("drop_done", LW'(got), LW'(1'b1));
    chk("drop_i_rdata", b0.I_READDATA, 128'h99);
    @(negedge CLK);

    // held request: exactly one low busywait cycle per completed transaction
    lat0 = 0; rdata0 = 128'h4040;
    b0.I_READ = 1'b1; b0.I_ADDRESS = 28'h40; lows = 0; first_low = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (!b0.I_BUSYWAIT) begin
        lows++;
        if (first_low == 0) first_low = k;
      end
    end
    b0.I_READ = 1'b0;
    repeat (3) @(negedge CLK);
    chk("held_low_count", LW'(lows), LW'(1));
    chk("held_first_low", LW'(first_low), LW'(3));
    chk("held_i_rdata", b0.I_READDATA, 128'h4040);

    // simultaneous D write-back and I fill, round-robin
    do_reset();
    base0 = log0.size(); lat0 = 0; rdata0 = 128'h8888;
    b0.D_WRITE = 1'b1; b0.D_ADDRESS = 28'h3; b0.D_WRITEDATA = 128'h1234;
    b0.I_READ = 1'b1; b0.I_ADDRESS = 28'h8;
    fin = 1'b0; dropped = 1'b0; d_done = 0; d_hi = 0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge CLK);
      if (!b0.D_BUSYWAIT && b0.D_WRITE) begin
        b0.D_WRITE = 1'b0; d_done = cyc; dropped = 1'b1;
      end else if (dropped && b0.D_BUSYWAIT) d_hi++;
      if (!b0.I_BUSYWAIT && b0.I_READ) b0.I_READ = 1'b0;
      fin = !(b0.I_READ | b0.D_WRITE);
    end
    chk("sim_done", LW'(fin), LW'(1'b1));
    chk("sim_count", LW'(log0.size() - base0), LW'(2));
    if (log0.size() - base0 == 2) begin
      chk("sim_first_wr", LW'(log0[base0].wr), LW'(1'b1));
      chk("sim_first_addr", LW'(log0[base0].addr), LW'(28'h3));
      chk("sim_first_wdata", log0[base0].wdata, 128'h1234);
      chk("sim_second_wr", LW'(log0[base0+1].wr), LW'(1'b0));
      chk("sim_second_addr", LW'(log0[base0+1].addr), LW'(28'h8));
      chk("sim_i_issue_cycle", LW'(logc0[base0+1]), LW'(d_done + 2));
    end
    chk("sim_d_busy_after_drop", LW'(d_hi), LW'(0));
    chk("sim_i_rdata", b0.I_READDATA, 128'h8888);

    // dirty-miss pattern with I continuously requesting, both arbitration modes
    do_reset();
    base0 = log0.size(); base1 = log1.size();
    lat0 = 0; lat1 = 0; rdata0 = 128'h4444; rdata1 = 128'h5555;
    b0.D_WRITE = 1'b1; b0.D_ADDRESS = 28'hA0; b0.D_WRITEDATA = 128'hAAAA;
    b0.I_READ = 1'b1; b0.I_ADDRESS = 28'hB0;
    b1.D_WRITE = 1'b1; b1.D_ADDRESS = 28'hA0; b1.D_WRITEDATA = 128'hAAAA;
    b1.I_READ = 1'b1; b1.I_ADDRESS = 28'hB0;
    fin = 1'b0;
    for (int k = 0; k < 80 && !fin; k++) begin
      @(negedge CLK);
      if (!b0.D_BUSYWAIT && b0.D_WRITE) begin
        b0.D_WRITE = 1'b0; b0.D_READ = 1'b1; b0.D_ADDRESS = 28'hA1;
      end else if (!b0.D_BUSYWAIT && b0.D_READ) b0.D_READ = 1'b0;
      if (!b0.I_BUSYWAIT && b0.I_READ) b0.I_READ = 1'b0;
      if (!b1.D_BUSYWAIT && b1.D_WRITE) begin
        b1.D_WRITE = 1'b0; b1.D_READ = 1'b1; b1.D_ADDRESS = 28'hA1;
      end else if (!b1.D_BUSYWAIT && b1.D_READ) b1.D_READ = 1'b0;
      if (!b1.I_BUSYWAIT && b1.I_READ) b1.I_READ = 1'b0;
      fin = !(b0.I_READ | b0.D_READ | b0.D_WRITE | b1.I_READ | b1.D_READ | b1.D_WRITE);
    end
    chk("dirty_done", LW'(fin), LW'(1'b1));
    chk("rr_count", LW'(log0.size() - base0), LW'(3));
    chk("fp_count", LW'(log1.size() - base1), LW'(3));
    if (log0.size() - base0 == 3 && log1.size() - base1 == 3) begin
      chk("rr_order0", LW'({log0[base0].wr, log0[base0].addr}), LW'({1'b1, 28'hA0}));
      chk("rr_order1", LW'({log0[base0+1].wr, log0[base0+1].addr}), LW'({1'b0, 28'hB0}));
      chk("rr_order2", LW'({log0[base0+2].wr, log0[base0+2].addr}), LW'({1'b0, 28'hA1}));
      chk("fp_order0", LW'({log1[base1].wr, log1[base1].addr}), LW'({1'b1, 28'hA0}));
      chk("fp_order1", LW'({log1[base1+1].wr, log1[base1+1].addr}), LW'({1'b0, 28'hA1}));
      chk("fp_order2", LW'({log1[base1+2].wr, log1[base1+2].addr}), LW'({1'b0, 28'hB0}));
    end
    chk("fp_d_rdata", b1.D_READDATA, 128'h5555);
    chk("rr_i_rdata", b0.I_READDATA, 128'h4444);
    @(negedge CLK);

    // watchdog: memory never answers
    stuck0 = 1'b1; rdata0 = 128'hDEAD;
    b0.I_READ = 1'b1; b0.I_ADDRESS = 28'h12;
    scnt = 0; got = 1'b0; err_last = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge CLK);
      if (!b0.I_BUSYWAIT) got = 1'b1;
      else begin
        if (b0.MEM_READ) scnt++;
        err_last = b0.ARB_ERR;
      end
    end
    chk("to_done", LW'(got), LW'(1'b1));
    chk("to_strobe_cycles", LW'(scnt), LW'(TO + 1));
    chk("to_err_before_done", LW'(err_last), LW'(1'b0));
    chk("to_err", LW'(b0.ARB_ERR), LW'(1'b1));
    chk("to_i_rdata_kept", b0.I_READDATA, 128'h4444);
    b0.I_READ = 1'b0; stuck0 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("to_err_sticky", LW'(b0.ARB_ERR), LW'(1'b1));

    // reset during WAIT, held request re-granted afterwards
    stuck0 = 1'b1;
    b0.I_READ = 1'b1; b0.I_ADDRESS = 28'h66;
    repeat (3) @(negedge CLK);
    chk("mid_wait_strobe", LW'(b0.MEM_READ), LW'(1'b1));
    #2 RESET = 1'b0;
    #1;
    chk("mid_rst_strobe", LW'(b0.MEM_READ), LW'(1'b0));
    chk("mid_rst_err", LW'(b0.ARB_ERR), LW'(1'b0));
    chk("mid_rst_i_rdata", b0.I_READDATA, '0);
    chk("mid_rst_addr", LW'(b0.MEM_ADDRESS), '0);
    @(negedge CLK);
    stuck0 = 1'b0; lat0 = 0; rdata0 = 128'h6666;
    RESET = 1'b1;
    @(negedge CLK);
    chk("regrant_strobe", LW'(b0.MEM_READ), LW'(1'b1));
    chk("regrant_addr", LW'(b0.MEM_ADDRESS), LW'(28'h66));
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge CLK);
      if (!b0.I_BUSYWAIT) got = 1'b1;
    end
    chk("regrant_done", LW'(got), LW'(1'b1));
    chk("regrant_i_rdata", b0.I_READDATA, 128'h6666);
    b0.I_READ = 1'b0;
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
